// File: rtl/addr_cal.sv
// addr_cal: sprite-memory address calculator.
// For each raster position the block decides whether the pixel falls inside
// the visible sprite and, if so, which sprite-memory word holds it. Results
// are registered one cycle after the inputs are sampled.
// Optional feature macro: ADDR_CAL_HFLIP_EN (enables horizontal mirroring
// through sprite_info[30]); when undefined the hflip bit is ignored.
module addr_cal (
   input  logic        clk,
   input  logic        reset,
   input  logic [79:0] pattern_info,
   input  logic [31:0] sprite_info,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   output logic [15:0] addr_output,
   output logic        valid
);

   // Smaller of two unsigned 16-bit dimensions.
   function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] m;
      if (a < b) begin
         m = a;
      end else begin
         m = b;
      end
      return m;
   endfunction

   // Descriptor fields
   logic [15:0] base_addr_s;
   logic [15:0] native_w_s;
   logic [15:0] native_h_s;
   logic [15:0] disp_w_s;
   logic [15:0] disp_h_s;
   logic        visible_s;
   logic        hflip_s;
   logic [9:0]  pos_x_s;
   logic [9:0]  pos_y_s;
   logic [9:0]  shift_s;

   assign base_addr_s = pattern_info[79:64];
   assign native_w_s  = pattern_info[63:48];
   assign native_h_s  = pattern_info[47:32];
   assign disp_w_s    = pattern_info[31:16];
   assign disp_h_s    = pattern_info[15:0];
   assign visible_s   = sprite_info[31];
   assign hflip_s     = sprite_info[30];
   assign pos_x_s     = sprite_info[29:20];
   assign pos_y_s     = sprite_info[19:10];
   assign shift_s     = sprite_info[9:0];

   // Datapath intermediates
   logic signed [11:0] dx_s;
   logic signed [11:0] dy_s;
   logic [15:0]        eff_w_s;
   logic [15:0]        eff_h_s;
   logic [16:0]        dx_u17_s;
   logic [16:0]        dy_u17_s;
   logic               inside_s;
   logic [15:0]        col_s;
   logic [15:0]        row_off_s;
   logic [15:0]        addr_s;

   // Offsets are taken at 12 bits signed so a pixel left of or above the
   // sprite gives a negative value instead of wrapping to a large positive.
   assign dx_s = $signed({2'b00, hcount}) - $signed({2'b00, pos_x_s});
   assign dy_s = $signed({2'b00, vcount}) - $signed({2'b00, pos_y_s});

   // Inside test and address arithmetic for the current pixel.
   always_comb begin
      eff_w_s   = min16(native_w_s, disp_w_s);
      eff_h_s   = min16(native_h_s, disp_h_s);
      dx_u17_s  = {6'd0, dx_s[10:0]};
      dy_u17_s  = {6'd0, dy_s[10:0]};
      inside_s  = 1'b0;
      col_s     = 16'd0;
      row_off_s = 16'd0;
      addr_s    = 16'd0;

      // Negative offsets are rejected before the unsigned range compare;
      // a zero effective size makes the compare fail on its own.
      if (visible_s && !dx_s[11] && !dy_s[11] &&
          (dx_u17_s < {1'b0, eff_w_s}) && (dy_u17_s < {1'b0, eff_h_s})) begin
         inside_s = 1'b1;
      end else begin
         inside_s = 1'b0;
      end

`ifdef ADDR_CAL_HFLIP_EN
      if (hflip_s) begin
         col_s = native_w_s - 16'd1 - dx_u17_s[15:0];
      end else begin
         col_s = dx_u17_s[15:0];
      end
`else
      // Mirroring is not built in: the hflip bit has no effect.
      if (hflip_s || !hflip_s) begin
         col_s = dx_u17_s[15:0];
      end else begin
         col_s = dx_u17_s[15:0];
      end
`endif

      // All sums wrap modulo 2^16.
      row_off_s = 16'(dy_u17_s[15:0] * native_w_s);
      addr_s    = base_addr_s + {6'd0, shift_s} + row_off_s + col_s;
   end

   // Output register: reset wins, outside pixels give zero address.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid       <= 1'b0;
         addr_output <= 16'h0000;
      end else if (inside_s) begin
         valid       <= 1'b1;
         addr_output <= addr_s;
      end else begin
         valid       <= 1'b0;
         addr_output <= 16'h0000;
      end
   end

endmodule

// File: tb/tb_addr_cal.sv
// Directed testbench for addr_cal with hand-computed expected values.
// Honours ADDR_CAL_HFLIP_EN for the mirrored-column expectations.
module tb_addr_cal;

   logic        clk;
   logic        reset;
   logic [79:0] pattern_info;
   logic [31:0] sprite_info;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [15:0] addr_output;
   logic        valid;

   int total;
   int bad;

   addr_cal dut (
      .clk          (clk),
      .reset        (reset),
      .pattern_info (pattern_info),
      .sprite_info  (sprite_info),
      .hcount       (hcount),
      .vcount       (vcount),
      .addr_output  (addr_output),
      .valid        (valid)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [79:0] mk_pat(input logic [15:0] base, input logic [15:0] nw,
                                          input logic [15:0] nh, input logic [15:0] dw,
                                          input logic [15:0] dh);
      return {base, nw, nh, dw, dh};
   endfunction

   function automatic logic [31:0] mk_spr(input logic vis, input logic hf, input logic [9:0] x,
                                          input logic [9:0] y, input logic [9:0] sh);
      return {vis, hf, x, y, sh};
   endfunction

   // Advance one edge with the current inputs, then compare valid/address.
   task automatic step_check(input string tag, input logic exp_v, input logic [15:0] exp_a);
      @(posedge clk);
      #1;
      total++;
      assert ({valid, addr_output} === {exp_v, exp_a})
      else begin
         bad++;
         $error("FAIL %s: got valid=%0b addr=%0d, want valid=%0b addr=%0d",
                tag, valid, addr_output, exp_v, exp_a);
      end
   endtask

   // Directed sequence.
   initial begin
      logic [15:0] flip_a;
      logic [15:0] flip_edge_a;
      total = 0;
      bad   = 0;
`ifdef ADDR_CAL_HFLIP_EN
      flip_a      = 16'd20;
      flip_edge_a = 16'd23;
`else
      flip_a      = 16'd19;
      flip_edge_a = 16'd16;
`endif

      // Reset with an inside pixel on the inputs.
      reset        = 1'b1;
      pattern_info = mk_pat(16'd0, 16'd8, 16'd16, 16'd8, 16'd16);
      sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
      hcount       = 10'd103;
      vcount       = 10'd52;
      step_check("reset", 1'b0, 16'h0000);

      reset = 1'b0;
      step_check("basic", 1'b1, 16'd19);

      sprite_info = mk_spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0);
      step_check("hflip", 1'b1, flip_a);
      hcount = 10'd100;
      step_check("hflip_col0", 1'b1, flip_edge_a);

      sprite_info = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
      hcount = 10'd108;
      step_check("right_edge", 1'b0, 16'h0000);
      hcount = 10'd99;
      step_check("left_of", 1'b0, 16'h0000);
      hcount = 10'd103; vcount = 10'd66;
      step_check("below", 1'b0, 16'h0000);
      hcount = 10'd100; vcount = 10'd65;
      step_check("last_row", 1'b1, 16'd120);
      vcount = 10'd49;
      step_check("above", 1'b0, 16'h0000);

      pattern_info = mk_pat(16'd128, 16'd8, 16'd16, 16'd8, 16'd16);
      sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd5);
      hcount = 10'd103; vcount = 10'd52;
      step_check("base_shift", 1'b1, 16'd152);
      sprite_info = mk_spr(1'b0, 1'b0, 10'd100, 10'd50, 10'd5);
      step_check("invisible", 1'b0, 16'h0000);

      pattern_info = mk_pat(16'd0, 16'd8, 16'd16, 16'd4, 16'd16);
      sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
      hcount = 10'd104;
      step_check("disp_w_edge", 1'b0, 16'h0000);
      hcount = 10'd103;
      step_check("disp_w_in", 1'b1, 16'd19);

      pattern_info = mk_pat(16'd0, 16'd0, 16'd16, 16'd8, 16'd16);
      hcount = 10'd100; vcount = 10'd50;
      step_check("native_w0", 1'b0, 16'h0000);
      pattern_info = mk_pat(16'd0, 16'd8, 16'd16, 16'd8, 16'd0);
      step_check("disp_h0", 1'b0, 16'h0000);

      pattern_info = mk_pat(16'hFFFF, 16'd8, 16'd16, 16'd8, 16'd16);
      step_check("wrap_ffff", 1'b1, 16'hFFFF);
      hcount = 10'd101;
      step_check("wrap_0", 1'b1, 16'h0000);

      // Reset in mid-frame, then recovery on the next edge.
      pattern_info = mk_pat(16'd0, 16'd8, 16'd16, 16'd8, 16'd16);
      hcount = 10'd103; vcount = 10'd52;
      step_check("pre_reset", 1'b1, 16'd19);
      reset = 1'b1;
      step_check("mid_reset", 1'b0, 16'h0000);
      reset = 1'b0;
      step_check("post_reset", 1'b1, 16'd19);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addr_cal.md
ADDR_CAL -- requirements
Module: addr_cal

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pattern_info  input  80  sprite pattern descriptor: [79:64] base_addr, [63:48] native_w, [47:32] native_h, [31:16] disp_w, [15:0] disp_h (unsigned).
REQ-005 sprite_info  input  32  per-instance state: [31] visible, [30] hflip, [29:20] pos_x, [19:10] pos_y, [9:0] shift (unsigned address offset).
REQ-006 hcount  input  10  current raster column (unsigned).
REQ-007 vcount  input  10  current raster row (unsigned).
REQ-008 addr_output  output  16  registered sprite-memory address of the current pixel.
REQ-009 valid  output  1  registered flag; 1 when the current pixel lies inside the visible sprite.

Function
REQ-010 dx = hcount - pos_x and dy = vcount - pos_y SHALL be computed at 11 bits or wider, signed, with no wrap-around.
REQ-011 Effective width eff_w SHALL be min(native_w, disp_w); effective height eff_h SHALL be min(native_h, disp_h).
REQ-012 A pixel is inside when visible=1, 0<=dx<eff_w and 0<=dy<eff_h; the inside test SHALL use unsigned comparisons at 17 or more bits.
REQ-013 The column index SHALL be col = native_w-1-dx when hflip=1 (and the flip feature is compiled in); otherwise col = dx.
REQ-014 The address SHALL be base_addr + shift + dy*native_w + col, truncated to 16 bits (modulo 2^16 wrap).
REQ-015 Latency: valid and addr_output SHALL register the result for the inputs sampled at the same rising edge, one cycle after those inputs.
REQ-016 When the pixel is not inside, valid SHALL be 0 and addr_output SHALL be 0.
REQ-017 A native_w, native_h, disp_w or disp_h of 0 SHALL make valid 0 for every pixel.
REQ-018 The right and bottom edges are exclusive: dx=eff_w or dy=eff_h SHALL give valid=0.
REQ-019 Changes to pattern_info or sprite_info SHALL take effect on the next rising edge, with no hold-off or handshake.
REQ-020 The block SHALL contain no other state: it is a purely registered combinational datapath.

Reset
REQ-021 While reset=1 at a rising edge, the block SHALL drive valid=0 and addr_output=16'h0000.
REQ-022 Reset SHALL take priority over the datapath; a reset in mid-frame SHALL produce valid=0 for that cycle, and normal results SHALL follow from the first edge after reset deasserts.

Configuration
REQ-023 Macro ADDR_CAL_HFLIP_EN: when defined, sprite_info[30] SHALL mirror the column as in REQ-013.
REQ-024 When ADDR_CAL_HFLIP_EN is not defined, sprite_info[30] SHALL be ignored and col SHALL equal dx.

Verification
REQ-025 pattern_info={0,8,16,8,16}, sprite visible with x=100, y=50, shift=0, hflip=0; hcount=103, vcount=52 -> next cycle valid=1, addr_output=19.
REQ-026 Same setup with hflip=1 and ADDR_CAL_HFLIP_EN defined -> addr_output=20; with the macro undefined -> addr_output=19.
REQ-027 Edge cases: hcount=108 -> valid=0; hcount=99 -> valid=0; vcount=66 -> valid=0; hcount=100, vcount=65 -> valid=1, addr_output=120.
REQ-028 base_addr=128, shift=5, hcount=103, vcount=52 -> addr_output=152; visible=0 -> valid=0 and addr_output=0.
REQ-029 disp_w=4 with native_w=8: hcount=104 -> valid=0; hcount=103 -> valid=1.
REQ-030 Assert reset while a pixel is inside -> valid=0 and addr_output=0 on that edge; deassert reset -> valid=1 on the following edge.
